// File: rtl/unexpected_msg_store.sv
// ---------------------------------------------------------------------------
// unexpected_msg_store
//
// Age-ordered store for eager MPI messages that arrive before a matching
// receive is posted. Index 0 holds the oldest entry. Valid entries always
// sit contiguously in indices 0..count-1.
//
// A lookup matches on (source, tag). Either field can be a wildcard. The
// oldest matching entry is returned one cycle later and removed, which
// preserves MPI non-overtaking order. Younger entries shift down to close
// the gap. A write in the same cycle lands at the new tail.
//
// Ports:
//   clk, rst              single clock; synchronous active-high reset
//   wr_valid/wr_ready     network write handshake (ready = count < DEPTH)
//   wr_src/tag/data       packet being written
//   rd_req                single-cycle lookup strobe
//   rd_src/tag            lookup key
//   rd_any_src/any_tag    wildcard enables for the key fields
//   rsp_valid             one-cycle pulse, one cycle after rd_req
//   rsp_hit               a match was found and removed
//   rsp_src/tag/data      matched entry, or zero on a miss
//   count, empty, full    occupancy, from the registered count only
// ---------------------------------------------------------------------------
module unexpected_msg_store #(
    parameter int DATA_WIDTH = 128,
    parameter int SRC_WIDTH  = 4,
    parameter int TAG_WIDTH  = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [SRC_WIDTH-1:0]  wr_src,
    input  logic [TAG_WIDTH-1:0]  wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    input  logic [SRC_WIDTH-1:0]  rd_src,
    input  logic [TAG_WIDTH-1:0]  rd_tag,
    input  logic                  rd_any_src,
    input  logic                  rd_any_tag,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [SRC_WIDTH-1:0]  rsp_src,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  empty,
    output logic                  full
);

    // Entry storage and occupancy
    logic [SRC_WIDTH-1:0]  src_q  [DEPTH];
    logic [SRC_WIDTH-1:0]  src_d  [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_d  [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    // Registered response
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_hit_q,   rsp_hit_d;
    logic [SRC_WIDTH-1:0]  rsp_src_q,   rsp_src_d;
    logic [TAG_WIDTH-1:0]  rsp_tag_q,   rsp_tag_d;
    logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;

    // Lookup result against start-of-cycle contents
    logic                  hit;
    logic [CNT_WIDTH-1:0]  hit_idx;
    logic [SRC_WIDTH-1:0]  hit_src;
    logic [TAG_WIDTH-1:0]  hit_tag;
    logic [DATA_WIDTH-1:0] hit_data;

    logic                  wr_accept;
    logic [CNT_WIDTH-1:0]  wr_pos;

    // Status depends only on the registered count, so there is no
    // combinational path from rd_req to wr_ready.
    assign wr_ready  = (count_q < CNT_WIDTH'(DEPTH));
    assign full      = (count_q == CNT_WIDTH'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign wr_accept = wr_valid && wr_ready;

    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_src   = rsp_src_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_data  = rsp_data_q;

    // Priority search: the first match in ascending index order is the oldest.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned (which would infer a latch).
        hit      = 1'b0;
        hit_idx  = '0;
        hit_src  = '0;
        hit_tag  = '0;
        hit_data = '0;
        if (rd_req) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!hit && (CNT_WIDTH'(i) < count_q) &&
                    (rd_any_src || (src_q[i] == rd_src)) &&
                    (rd_any_tag || (tag_q[i] == rd_tag))) begin
                    hit      = 1'b1;
                    hit_idx  = CNT_WIDTH'(i);
                    hit_src  = src_q[i];
                    hit_tag  = tag_q[i];
                    hit_data = data_q[i];
                end
            end
        end
    end

    // Next state: shift out the removed entry, then append the new tail.
    always_comb begin
        src_d  = src_q;
        tag_d  = tag_q;
        data_d = data_q;

        // A removal moves the tail down one slot, so a concurrent write
        // lands at count-1 instead of count.
        wr_pos = hit ? (count_q - 1'b1) : count_q;

        for (int i = 0; i < DEPTH - 1; i++) begin
            if (hit && (CNT_WIDTH'(i) >= hit_idx)) begin
                src_d[i]  = src_q[i+1];
                tag_d[i]  = tag_q[i+1];
                data_d[i] = data_q[i+1];
            end
        end

        // The write is applied after the shift so it wins at the tail slot.
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_accept && (CNT_WIDTH'(i) == wr_pos)) begin
                src_d[i]  = wr_src;
                tag_d[i]  = wr_tag;
                data_d[i] = wr_data;
            end
        end

        case ({wr_accept, hit})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        rsp_valid_d = rd_req;
        rsp_hit_d   = hit;
        rsp_src_d   = hit_src;
        rsp_tag_d   = hit_tag;
        rsp_data_d  = hit_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the entry array is cleared on reset on purpose, so entries
            // beyond count start out as zeros rather than unknown values.
            for (int i = 0; i < DEPTH; i++) begin
                src_q[i]  <= '0;
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_src_q   <= '0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so that every
            // register samples the values from before this edge.
            src_q       <= src_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_src_q   <= rsp_src_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_unexpected_msg_store.sv
// ---------------------------------------------------------------------------
// tb_unexpected_msg_store
//
// Testbench for unexpected_msg_store.
//
// The reference model is an age-ordered queue of entries:
//   - A lookup searches the queue for the first match and deletes it.
//   - An accepted write is pushed onto the back of the queue.
//
// Each lookup pushes its expected response into a scoreboard queue. A
// separate monitor on the falling edge pops that queue and compares it
// with the response the DUT presents.
// ---------------------------------------------------------------------------
module tb_unexpected_msg_store;

    localparam int DW    = 128;
    localparam int SW    = 4;
    localparam int TW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [SW-1:0] wr_src = '0;
    logic [TW-1:0] wr_tag = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_req = 1'b0;
    logic [SW-1:0] rd_src = '0;
    logic [TW-1:0] rd_tag = '0;
    logic          rd_any_src = 1'b0;
    logic          rd_any_tag = 1'b0;
    logic          rsp_valid;
    logic          rsp_hit;
    logic [SW-1:0] rsp_src;
    logic [TW-1:0] rsp_tag;
    logic [DW-1:0] rsp_data;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    unexpected_msg_store #(
        .DATA_WIDTH(DW), .SRC_WIDTH(SW), .TAG_WIDTH(TW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_src(wr_src), .wr_tag(wr_tag), .wr_data(wr_data),
        .rd_req(rd_req), .rd_src(rd_src), .rd_tag(rd_tag),
        .rd_any_src(rd_any_src), .rd_any_tag(rd_any_tag),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
        .rsp_src(rsp_src), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] src;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        logic          hit;
        logic [SW-1:0] src;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } rsp_t;

    ent_t model[$];
    rsp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: compares every presented response with the scoreboard.
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (rsp_valid !== 1'b0 || exp_q.size() != 0) begin
            check("rsp_valid", DW'(rsp_valid), DW'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rsp_hit",  DW'(rsp_hit), DW'(e.hit));
                check("rsp_src",  DW'(rsp_src), DW'(e.src));
                check("rsp_tag",  DW'(rsp_tag), DW'(e.tag));
                check("rsp_data", rsp_data,     e.data);
            end
        end
    end

    // One clock cycle of stimulus. Status outputs are checked against the
    // model before the edge. The model is updated right after the edge.
    task automatic step(input logic wv, input logic [SW-1:0] ws, input logic [TW-1:0] wt,
                        input logic [DW-1:0] wd, input logic rq, input logic [SW-1:0] rs,
                        input logic [TW-1:0] rt, input logic as, input logic at);
        bit   acc;
        rsp_t e;
        ent_t n;
        @(negedge clk);
        check("count",    DW'(count),    DW'(model.size()));
        check("empty",    DW'(empty),    DW'(model.size() == 0));
        check("full",     DW'(full),     DW'(model.size() == DEPTH));
        check("wr_ready", DW'(wr_ready), DW'(model.size() < DEPTH));
        wr_valid = wv; wr_src = ws; wr_tag = wt; wr_data = wd;
        rd_req = rq; rd_src = rs; rd_tag = rt; rd_any_src = as; rd_any_tag = at;
        @(posedge clk);
        acc = wv && (model.size() < DEPTH);
        if (rq) begin
            e.hit = 1'b0; e.src = '0; e.tag = '0; e.data = '0;
            for (int i = 0; i < model.size(); i++) begin
                if ((as || model[i].src == rs) && (at || model[i].tag == rt)) begin
                    e.hit = 1'b1; e.src = model[i].src; e.tag = model[i].tag; e.data = model[i].data;
                    model.delete(i);
                    break;
                end
            end
            exp_q.push_back(e);
        end
        if (acc) begin
            n.src = ws; n.tag = wt; n.data = wd;
            model.push_back(n);
        end
    endtask

    task automatic wr(input logic [SW-1:0] s, input logic [TW-1:0] t, input logic [DW-1:0] d);
        step(1'b1, s, t, d, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [SW-1:0] s, input logic [TW-1:0] t, input logic as, input logic at);
        step(1'b0, '0, '0, '0, 1'b1, s, t, as, at);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Reset while a write and a lookup are both offered; neither may take effect.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wr_valid = 1'b1; wr_data = 'h55; rd_req = 1'b1; rd_any_src = 1'b1; rd_any_tag = 1'b1;
        @(posedge clk);
        model.delete();
        @(negedge clk);
        rst = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
        check("rst_count", DW'(count),     '0);
        check("rst_empty", DW'(empty),     DW'(1));
        check("rst_rsp",   DW'(rsp_valid), '0);
    endtask

    initial begin
        logic          hold;
        logic          wv, rq, as, at;
        logic [SW-1:0] ws, rs;
        logic [TW-1:0] wt, rt;
        logic [DW-1:0] wd;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_count", DW'(count),     '0);
        check("reset_empty", DW'(empty),     DW'(1));
        check("reset_full",  DW'(full),      '0);
        check("reset_ready", DW'(wr_ready),  DW'(1));
        check("reset_valid", DW'(rsp_valid), '0);
        check("reset_data",  rsp_data,       '0);
        rst = 1'b0;

        // Basic write then hit
        wr(3, 5, 'hAA);
        rd(3, 5, 0, 0);
        idle(1);

        // Same-key ordering, then a miss
        wr(2, 7, 'h11); wr(2, 7, 'h22); wr(2, 7, 'h33);
        repeat (4) rd(2, 7, 0, 0);
        idle(1);

        // Wildcards
        wr(1, 4, 'hA); wr(5, 9, 'hB); wr(5, 4, 'hC);
        rd(0, 4, 1, 0);
        rd(5, 0, 0, 1);
        idle(1);
        @(negedge clk);
        check("wild_count", DW'(count), DW'(1));
        rd(0, 0, 1, 1);
        idle(1);

        // Middle removal with a simultaneous write
        wr(0, 0, 1); wr(1, 1, 2); wr(2, 2, 3);
        step(1'b1, 3, 3, 4, 1'b1, 1, 1, 1'b0, 1'b0);
        repeat (3) rd(0, 0, 1, 1);
        idle(1);

        // Full: the held write is refused until a removal is visible
        for (int i = 0; i < DEPTH; i++) wr(SW'(i), TW'(i), DW'(i + 16));
        step(1'b1, 9, 9, 'h99, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 9, 9, 'h99, 1'b1, '0, '0, 1'b1, 1'b1);
        step(1'b1, 9, 9, 'h99, 1'b0, '0, '0, 1'b0, 1'b0);
        repeat (DEPTH) rd(0, 0, 1, 1);
        idle(1);

        // Same-cycle write is invisible to the lookup in that cycle
        step(1'b1, 6, 6, 'hF, 1'b1, 6, 6, 1'b0, 1'b0);
        rd(6, 6, 0, 0);
        idle(1);

        // Reset with count=4 and a lookup pending
        for (int i = 0; i < 4; i++) wr(SW'(i), 1, DW'(i));
        do_reset();
        idle(1);

        // Randomised traffic on a small key space so hits are frequent
        hold = 1'b0;
        ws = '0; wt = '0; wd = '0;
        for (int n = 0; n < 1500; n++) begin
            wv = ($urandom_range(0, 1) == 1);
            if (hold) wv = 1'b1;
            else begin
                ws = SW'($urandom_range(0, 3));
                wt = TW'($urandom_range(0, 3));
                wd = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            rq = ($urandom_range(0, 1) == 1);
            rs = SW'($urandom_range(0, 3));
            rt = TW'($urandom_range(0, 3));
            as = ($urandom_range(0, 3) == 0);
            at = ($urandom_range(0, 3) == 0);
            hold = wv && (model.size() >= DEPTH);
            step(wv, ws, wt, wd, rq, rs, rt, as, at);
        end
        idle(2);
        check("scoreboard_drained", DW'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
